// File: rtl/spike_isi_decoder_pkg.sv
// spike_isi_decoder_pkg
//   Shared definitions for the spike ISI decoder slice: the FSM state
//   encoding and the default widths and limits used by the decoder top.
//   No ports; imported by spike_isi_decoder.
package spike_isi_decoder_pkg;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_COUNT = 1'b1
   } state_t;

   localparam int ISI_W_DEFAULT       = 16;
   localparam int ISI_DEPTH_DEFAULT   = 4;
   localparam int ISI_MIN_ISI_DEFAULT = 2;

endpackage

// File: rtl/spike_isi_decoder_fifo.sv
// isi_fifo
//   Synchronous first-word fall-through FIFO holding {sat, isi} entries for
//   the spike ISI decoder. The head entry is always present on rd_data and
//   becomes visible the cycle after it is written.
// Ports
//   clk      in   1      clock, rising edge
//   rstn     in   1      synchronous reset, active low (empties the FIFO)
//   push     in   1      write request; accepted when not full or when a pop
//                        happens in the same cycle
//   wr_data  in   DW     entry to write
//   pop      in   1      read request; ignored while empty
//   rd_data  out  DW     head entry
//   full     out  1      all DEPTH entries occupied
//   empty    out  1      no entries
module isi_fifo #(
   parameter int DW    = 17,
   parameter int DEPTH = 4
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          push,
   input  logic [DW-1:0] wr_data,
   input  logic          pop,
   output logic [DW-1:0] rd_data,
   output logic          full,
   output logic          empty
);

   localparam int AW = $clog2(DEPTH);

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic [DW-1:0] mem [DEPTH];
   logic          do_push;
   logic          do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop & ~empty;
   // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
   assign do_push = push & (~full | do_pop);
   assign rd_data = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   // Storage is not reset; stale contents are never observed because the
   // decoder masks the head while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/spike_isi_decoder.sv
// spike_isi_decoder
//   Converts a neuron spike pulse train into inter-spike intervals measured
//   in clock cycles and queues them on a valid/ready stream.
// Ports
//   clk        in   1  clock, rising edge
//   rstn       in   1  synchronous reset, active low
//   en         in   1  decoder enable
//   spike      in   1  spike input, synchronous to clk
//   isi_data   out  W  ISI at the FIFO head (0 while empty)
//   isi_valid  out  1  FIFO not empty
//   isi_ready  in   1  consumer accepts the head entry
//   overflow   out  1  sticky: an ISI was dropped because the FIFO was full
//   ovf_clr    in   1  clears overflow (a same-cycle drop wins)
//   sat        out  1  head entry holds the saturated count 2^W-1
module spike_isi_decoder
   import spike_isi_decoder_pkg::*;
#(
   parameter int W       = ISI_W_DEFAULT,
   parameter int DEPTH   = ISI_DEPTH_DEFAULT,
   parameter int MIN_ISI = ISI_MIN_ISI_DEFAULT
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         en,
   input  logic         spike,
   output logic [W-1:0] isi_data,
   output logic         isi_valid,
   input  logic         isi_ready,
   output logic         overflow,
   input  logic         ovf_clr,
   output logic         sat
);

   localparam logic [W-1:0] CNT_MAX   = '1;
   localparam logic [W-1:0] MIN_ISI_W = W'(MIN_ISI);

   state_t       state;
   state_t       state_nxt;
   logic [W-1:0] cnt;
   logic [W-1:0] cnt_nxt;
   logic         spike_d;
   logic         spike_edge;
   logic         push;
   logic         drop;
   logic         fifo_full;
   logic         fifo_empty;
   logic [W:0]   fifo_head;

   // A spike held high for several cycles yields a single rising edge.
   assign spike_edge = spike & ~spike_d;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state   <= S_IDLE;
         cnt     <= '0;
         spike_d <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         spike_d <= spike;
      end
   end

   // The first edge only arms the counter. In COUNT, an edge that arrives
   // before MIN_ISI cycles is a glitch: it neither pushes nor restarts.
   // Dropping en wins over any edge in the same cycle.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      push      = 1'b0;
      case (state)
         S_IDLE: begin
            if (en && spike_edge) begin
               state_nxt = S_COUNT;
               cnt_nxt   = W'(1);
            end
         end
         S_COUNT: begin
            if (!en) begin
               state_nxt = S_IDLE;
               cnt_nxt   = '0;
            end else if (spike_edge && (cnt >= MIN_ISI_W)) begin
               push    = 1'b1;
               cnt_nxt = W'(1);
            end else if (cnt != CNT_MAX) begin
               cnt_nxt = cnt + W'(1);
            end
         end
         default: begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   isi_fifo #(
      .DW    (W + 1),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rstn    (rstn),
      .push    (push),
      .wr_data ({(cnt == CNT_MAX), cnt}),
      .pop     (isi_ready),
      .rd_data (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // A full FIFO only loses the entry when no pop frees a slot this cycle.
   assign drop = push & fifo_full & ~(isi_ready & ~fifo_empty);

   always_ff @(posedge clk) begin
      if (!rstn) begin
         overflow <= 1'b0;
      end else if (drop) begin
         overflow <= 1'b1;
      end else if (ovf_clr) begin
         overflow <= 1'b0;
      end
   end

   assign isi_valid = ~fifo_empty;
   assign isi_data  = fifo_empty ? '0 : fifo_head[W-1:0];
   assign sat       = ~fifo_empty & fifo_head[W];

endmodule

// File: tb/tb_spike_isi_decoder.sv
// tb_spike_isi_decoder
//   Self-checking bench for spike_isi_decoder. A reference model tracks the
//   cycle number of the last accepted spike edge and a queue of pending ISIs,
//   and every cycle the DUT outputs are compared against it.
module tb_spike_isi_decoder;

   localparam int W       = 6;
   localparam int DEPTH   = 4;
   localparam int MIN_ISI = 3;
   localparam int MAXV    = (1 << W) - 1;

   logic         clk;
   logic         rstn;
   logic         en;
   logic         spike;
   logic [W-1:0] isi_data;
   logic         isi_valid;
   logic         isi_ready;
   logic         overflow;
   logic         ovf_clr;
   logic         sat;

   int total_cnt;
   int bad_cnt;

   // Reference model state
   int q_val[$];
   bit q_sat[$];
   bit ovf_m;
   bit armed;
   int t0;
   int now;
   bit prev_spike;

   // Values the DUT handed out on accepted handshakes
   int dut_pops[$];

   spike_isi_decoder #(
      .W       (W),
      .DEPTH   (DEPTH),
      .MIN_ISI (MIN_ISI)
   ) dut (
      .clk       (clk),
      .rstn      (rstn),
      .en        (en),
      .spike     (spike),
      .isi_data  (isi_data),
      .isi_valid (isi_valid),
      .isi_ready (isi_ready),
      .overflow  (overflow),
      .ovf_clr   (ovf_clr),
      .sat       (sat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total_cnt++;
      if (got !== exp) begin
         bad_cnt++;
         $display("[TB] FAIL %s got=%0d expected=%0d (cycle %0d)", tag, got, exp, now);
      end
   endtask

   // Drives one cycle of inputs, checks outputs mid-cycle, advances the model
   // by the effect of the coming clock edge, then steps past that edge.
   task automatic applyStimulus(input logic r, input logic e, input logic s,
                                input logic rdy, input logic clr);
      bit spike_rise;
      bit popping;
      bit pushing;
      bit dropping;
      int v;
      int sz;
      rstn      = r;
      en        = e;
      spike     = s;
      isi_ready = rdy;
      ovf_clr   = clr;
      @(negedge clk);
      checkOutput("isi_valid", 32'(isi_valid), 32'(q_val.size() != 0));
      checkOutput("isi_data", 32'(isi_data), (q_val.size() != 0) ? q_val[0] : 0);
      checkOutput("sat", 32'(sat), (q_val.size() != 0) ? 32'(q_sat[0]) : 0);
      checkOutput("overflow", 32'(overflow), 32'(ovf_m));
      if (r && isi_valid && rdy) dut_pops.push_back(int'(isi_data));
      if (!r) begin
         q_val.delete();
         q_sat.delete();
         ovf_m      = 1'b0;
         armed      = 1'b0;
         prev_spike = 1'b0;
      end else begin
         spike_rise = s && !prev_spike;
         sz         = q_val.size();
         popping    = rdy && (sz != 0);
         pushing    = 1'b0;
         v          = 0;
         if (!e) begin
            armed = 1'b0;
         end else if (spike_rise) begin
            if (!armed) begin
               armed = 1'b1;
               t0    = now;
            end else if (now - t0 >= MIN_ISI) begin
               pushing = 1'b1;
               v       = (now - t0 > MAXV) ? MAXV : now - t0;
               t0      = now;
            end
         end
         dropping = pushing && (sz == DEPTH) && !popping;
         if (popping) begin
            void'(q_val.pop_front());
            void'(q_sat.pop_front());
         end
         if (pushing && !dropping) begin
            q_val.push_back(v);
            q_sat.push_back(v == MAXV);
         end
         if (dropping)  ovf_m = 1'b1;
         else if (clr)  ovf_m = 1'b0;
         prev_spike = s;
      end
      now++;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int spike_pct;
      int ready_pct;
      int pops_n;
      total_cnt  = 0;
      bad_cnt    = 0;
      now        = 0;
      t0         = 0;
      armed      = 1'b0;
      ovf_m      = 1'b0;
      prev_spike = 1'b0;
      rstn       = 1'b0;
      en         = 1'b0;
      spike      = 1'b0;
      isi_ready  = 1'b0;
      ovf_clr    = 1'b0;

      // Reset: outputs must come up at zero.
      repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

      // Two intervals 25 and 10 read out with the consumer always ready.
      dut_pops.delete();
      for (int k = 0; k < 50; k++)
         applyStimulus(1'b1, 1'b1, (k == 10 || k == 35 || k == 45), 1'b1, 1'b0);
      checkOutput("basic_pop_count", dut_pops.size(), 2);
      if (dut_pops.size() >= 2) begin
         checkOutput("basic_isi0", dut_pops[0], 25);
         checkOutput("basic_isi1", dut_pops[1], 10);
      end

      // Six intervals of 5 into a stalled consumer: four kept, rest dropped.
      repeat (2) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 33; k++)
         applyStimulus(1'b1, 1'b1, (k % 5 == 0), 1'b0, 1'b0);
      checkOutput("ovf_set", 32'(overflow), 32'd1);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      checkOutput("ovf_cleared", 32'(overflow), 32'd0);
      dut_pops.delete();
      repeat (8) applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      checkOutput("drain_count", dut_pops.size(), DEPTH);
      pops_n = 0;
      foreach (dut_pops[i]) if (dut_pops[i] == 5) pops_n++;
      checkOutput("drain_values", pops_n, DEPTH);

      // Long gap saturates, then a disabled decoder leaves queued data alone.
      repeat (2) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 90; k++)
         applyStimulus(1'b1, 1'b1, (k == 0 || k == 80), 1'b0, 1'b0);
      checkOutput("sat_flag", 32'(sat), 32'd1);
      checkOutput("sat_value", 32'(isi_data), MAXV);
      for (int k = 0; k < 20; k++)
         applyStimulus(1'b1, 1'b0, (k == 5 || k == 12), 1'b0, 1'b0);
      checkOutput("en_off_keeps", 32'(isi_valid), 32'd1);

      // Randomized phases varying spike density, consumer readiness and enable.
      for (int p = 0; p < 8; p++) begin
         case (p % 4)
            0: begin spike_pct = 20; ready_pct = 90; end
            1: begin spike_pct = 35; ready_pct = 10; end
            2: begin spike_pct = 1;  ready_pct = 50; end
            default: begin spike_pct = 50; ready_pct = 40; end
         endcase
         for (int k = 0; k < 500; k++)
            applyStimulus(($urandom_range(0, 599) != 0),
                           ($urandom_range(0, 99) >= 3),
                           ($urandom_range(0, 99) < spike_pct),
                           ($urandom_range(0, 99) < ready_pct),
                           ($urandom_range(0, 99) < 5));
      end

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule
